// File: rtl/music_pkg.sv
// Shared definitions for the per-voice music playback blocks.
// Contents: field widths, note_player state encoding, note-code to phase-step mapping.
// No ports; imported by frequency_rom and note_player.
package music_pkg;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;
   localparam int GAIN_W = 8;
   localparam int STEP_W = 20;

   typedef enum logic [1:0] {
      NP_IDLE    = 2'd0,
      NP_LOOKUP  = 2'd1,
      NP_PLAYING = 2'd2,
      NP_RELEASE = 2'd3
   } np_state_t;

   // Note code 1 is C2; each further code is one semitone up. Base steps are
   // f * 2^20 / 48 kHz for the C2..B2 octave, doubled per octave. Code 0 is a rest.
   function automatic logic [STEP_W-1:0] note_step(input logic [NOTE_W-1:0] code);
      logic [NOTE_W-1:0] idx;
      logic [2:0]        oct;
      logic [3:0]        semi;
      logic [STEP_W-1:0] base;
      if (code == '0) return '0;
      idx  = code - NOTE_W'(1);
      oct  = 3'(idx / NOTE_W'(12));
      semi = 4'(idx % NOTE_W'(12));
      case (semi)
         4'd0:    base = 20'd1429;
         4'd1:    base = 20'd1514;
         4'd2:    base = 20'd1604;
         4'd3:    base = 20'd1699;
         4'd4:    base = 20'd1800;
         4'd5:    base = 20'd1907;
         4'd6:    base = 20'd2021;
         4'd7:    base = 20'd2141;
         4'd8:    base = 20'd2268;
         4'd9:    base = 20'd2403;
         4'd10:   base = 20'd2546;
         default: base = 20'd2697;
      endcase
      return base << oct;
   endfunction

endpackage

// File: rtl/frequency_rom.sv
// Synchronous 64-entry note-code to phase-step ROM, one read per cycle.
// Latency: dout reflects addr one clock after it is presented.
// Ports: clk, addr (note code), dout (phase step). No reset, no flow control.
module frequency_rom
   import music_pkg::*;
(
   input  logic              clk,
   input  logic [5:0]        addr,
   output logic [STEP_W-1:0] dout
);

   always_ff @(posedge clk) begin
      dout <= note_step(addr);
   end

endmodule

// File: rtl/note_player.sv
// Per-voice note playback: note code -> phase step, beat countdown, linear attack/release gain.
// Latency: load_note at N gives active at N+1 and a valid step_size at N+2; all outputs registered.
// Ports: clk/reset, play (pause), beat/sample_tick strobes, load_note+note+duration in;
//        step_size, gain, active, note_done out. No backpressure: strobes act when they arrive.
module note_player
   import music_pkg::*;
#(
   parameter int          STEP_W       = 20,
   parameter logic [7:0]  ATTACK_STEP  = 8'd4,
   parameter logic [7:0]  RELEASE_STEP = 8'd2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              beat,
   input  logic              sample_tick,
   input  logic              load_note,
   input  logic [5:0]        note,
   input  logic [5:0]        duration,
   output logic [STEP_W-1:0] step_size,
   output logic [7:0]        gain,
   output logic              active,
   output logic              note_done
);

   np_state_t                   state_q, state_d;
   logic [NOTE_W-1:0]           note_q, note_d;
   logic [DUR_W-1:0]            beats_left_q, beats_left_d;
   logic [GAIN_W-1:0]           gain_q, gain_d;
   logic [STEP_W-1:0]           step_size_q, step_size_d;
   logic                        active_q, active_d;
   logic                        note_done_q, note_done_d;

   logic [5:0]                  rom_addr;
   logic [music_pkg::STEP_W-1:0] rom_dout;
   logic [GAIN_W:0]             gain_up;
   logic [GAIN_W-1:0]           gain_dn;

   // Address the ROM with the incoming note on the load cycle so its data is
   // ready during LOOKUP and can be captured on the LOOKUP->PLAYING edge.
   assign rom_addr = load_note ? note : note_q;

   frequency_rom u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .dout (rom_dout)
   );

   assign gain_up = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
   assign gain_dn = (gain_q > RELEASE_STEP) ? (gain_q - RELEASE_STEP) : '0;

   always_comb begin
      state_d      = state_q;
      note_d       = note_q;
      beats_left_d = beats_left_q;
      gain_d       = gain_q;
      step_size_d  = step_size_q;
      note_done_d  = 1'b0;

      if (load_note) begin
         // Retrigger from any state; gain is left alone so the new note starts without a click.
         note_d       = note;
         beats_left_d = (duration == '0) ? DUR_W'(1) : duration;
         state_d      = NP_LOOKUP;
      end else begin
         case (state_q)
            NP_IDLE: ;
            NP_LOOKUP: begin
               state_d     = NP_PLAYING;
               step_size_d = (note_q == '0) ? '0 : STEP_W'(rom_dout);
            end
            NP_PLAYING: begin
               if (play) begin
                  if (sample_tick) gain_d = gain_up[GAIN_W] ? '1 : gain_up[GAIN_W-1:0];
                  if (beat) begin
                     if (beats_left_q == DUR_W'(1)) state_d = NP_RELEASE;
                     else                           beats_left_d = beats_left_q - DUR_W'(1);
                  end
               end
            end
            NP_RELEASE: begin
               if (play) begin
                  if (sample_tick) gain_d = gain_dn;
                  // Leave as soon as gain hits zero, including a note that enters release silent.
                  if (gain_d == '0) begin
                     state_d     = NP_IDLE;
                     step_size_d = '0;
                     note_done_d = 1'b1;
                  end
               end
            end
            default: state_d = NP_IDLE;
         endcase
      end

      active_d = (state_d != NP_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= NP_IDLE;
         note_q       <= '0;
         beats_left_q <= '0;
         gain_q       <= '0;
         step_size_q  <= '0;
         active_q     <= 1'b0;
         note_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         note_q       <= note_d;
         beats_left_q <= beats_left_d;
         gain_q       <= gain_d;
         step_size_q  <= step_size_d;
         active_q     <= active_d;
         note_done_q  <= note_done_d;
      end
   end

   assign step_size = step_size_q;
   assign gain      = gain_q;
   assign active    = active_q;
   assign note_done = note_done_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios plus random strobes,
// every cycle compared against a behavioural note/envelope model.
// Drives inputs on the falling edge and samples outputs on the following falling edge.
module tb_note_player;

   logic        clk = 1'b0;
   logic        reset;
   logic        play, beat, sample_tick, load_note;
   logic [5:0]  note, duration;
   logic [19:0] step_size;
   logic [7:0]  gain;
   logic        active, note_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cycle_no = 0;

   always #5 clk = ~clk;

   note_player dut (
      .clk         (clk),
      .reset       (reset),
      .play        (play),
      .beat        (beat),
      .sample_tick (sample_tick),
      .load_note   (load_note),
      .note        (note),
      .duration    (duration),
      .step_size   (step_size),
      .gain        (gain),
      .active      (active),
      .note_done   (note_done)
   );

   // ---------------- behavioural reference ----------------
   localparam int M_IDLE = 0, M_LOOK = 1, M_PLAY = 2, M_REL = 3;
   int m_phase, m_gain, m_beats, m_step, m_note;
   bit m_done;

   // Equal-tempered steps: code 1 = C2 (65.41 Hz) at 48 kHz with a 2^20 phase wheel.
   function automatic int ref_step(input int code);
      int base[12];
      base = '{1429, 1514, 1604, 1699, 1800, 1907, 2021, 2141, 2268, 2403, 2546, 2697};
      if (code == 0) return 0;
      return base[(code - 1) % 12] * (1 << ((code - 1) / 12));
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE; m_gain = 0; m_beats = 0; m_step = 0; m_note = 0; m_done = 0;
   endtask

   task automatic model_step(input bit ld, input int nt, input int du,
                             input bit pl, input bit bt, input bit st);
      m_done = 0;
      if (ld) begin
         m_note  = nt;
         m_beats = (du == 0) ? 1 : du;
         m_phase = M_LOOK;
      end else if (m_phase == M_LOOK) begin
         m_step  = ref_step(m_note);
         m_phase = M_PLAY;
      end else if (pl && m_phase == M_PLAY) begin
         if (st) m_gain = (m_gain + 4 > 255) ? 255 : m_gain + 4;
         if (bt) begin
            if (m_beats == 1) m_phase = M_REL;
            else              m_beats = m_beats - 1;
         end
      end else if (pl && m_phase == M_REL) begin
         if (st) m_gain = (m_gain < 2) ? 0 : m_gain - 2;
         if (m_gain == 0) begin
            m_phase = M_IDLE;
            m_step  = 0;
            m_done  = 1;
         end
      end
   endtask

   // One clock: drive at the falling edge, let the DUT clock, compare at the next falling edge.
   task automatic cyc(input bit ld, input int nt, input int du,
                      input bit pl, input bit bt, input bit st);
      load_note = ld; note = 6'(nt); duration = 6'(du);
      play = pl; beat = bt; sample_tick = st;
      model_step(ld, nt, du, pl, bt, st);
      @(posedge clk);
      @(negedge clk);
      cycle_no++;
      checks++;
      if (step_size !== 20'(m_step)) begin
         errors++;
         $display("FAIL model_step_size cycle %0d: got %0d expected %0d", cycle_no, step_size, m_step);
      end
      checks++;
      if (gain !== 8'(m_gain)) begin
         errors++;
         $display("FAIL model_gain cycle %0d: got %0d expected %0d", cycle_no, gain, m_gain);
      end
      checks++;
      if (active !== (m_phase != M_IDLE)) begin
         errors++;
         $display("FAIL model_active cycle %0d: got %0b expected %0b", cycle_no, active, m_phase != M_IDLE);
      end
      checks++;
      if (note_done !== m_done) begin
         errors++;
         $display("FAIL model_note_done cycle %0d: got %0b expected %0b", cycle_no, note_done, m_done);
      end
      if (note_done === 1'b1) done_cnt++;
   endtask

   // Ticks every 4 cycles, beats every 50; counts beats up to the first gain drop, then runs to note_done.
   task automatic beats_until_release(output int nb, output bit done_seen);
      int prev;
      bit rel;
      nb = 0; rel = 0; done_seen = 0; prev = gain;
      for (int t = 1; t < 2000 && !done_seen; t++) begin
         bit bt, st;
         bt = (t % 50 == 0);
         st = (t % 4 == 0);
         cyc(1'b0, 0, 0, 1'b1, bt, st);
         if (bt && !rel) nb++;
         if (gain < prev) rel = 1;
         prev = gain;
         if (note_done === 1'b1) done_seen = 1;
      end
   endtask

   // Plays one note with ticks every 2 cycles and beats every 16; reports cycles until note_done.
   task automatic run_note(input int nt, input int du, output int ncyc, output bit step_seen, output bit fin);
      ncyc = 0; step_seen = 0; fin = 0;
      cyc(1'b1, nt, du, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t < 3000 && !fin; t++) begin
         cyc(1'b0, 0, 0, 1'b1, (t % 16 == 0), (t % 2 == 0));
         ncyc++;
         if (step_size != 0) step_seen = 1;
         if (note_done === 1'b1) fin = 1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; play = 1'b0; beat = 1'b0; sample_tick = 1'b0;
      load_note = 1'b0; note = '0; duration = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL reset_step_size: got %0d expected 0", step_size); end
      checks++; if (gain !== 8'd0)       begin errors++; $display("FAIL reset_gain: got %0d expected 0", gain); end
      checks++; if (active !== 1'b0)     begin errors++; $display("FAIL reset_active: got %0b expected 0", active); end
      checks++; if (note_done !== 1'b0)  begin errors++; $display("FAIL reset_note_done: got %0b expected 0", note_done); end
      reset = 1'b0;
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_basic();
      int max_gain = 0, beats_sent = 0, rel_ticks = 0, d0;
      bit got_done = 0;
      d0 = done_cnt;
      cyc(1'b1, 40, 3, 1'b1, 1'b0, 1'b0);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active_n1: got %0b expected 1", active); end
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (step_size !== 20'(ref_step(40))) begin
         errors++; $display("FAIL basic_step_n2: got %0d expected %0d", step_size, ref_step(40));
      end
      for (int t = 2; t < 3000 && !got_done; t++) begin
         bit st, bt;
         st = (t % 4 == 0);
         bt = (t % 200 == 0);
         if (beats_sent >= 3 && st) rel_ticks++;
         cyc(1'b0, 0, 0, 1'b1, bt, st);
         if (bt) beats_sent++;
         if (int'(gain) > max_gain) max_gain = gain;
         if (note_done === 1'b1) got_done = 1;
      end
      checks++; if (!got_done)        begin errors++; $display("FAIL basic_done_seen: got 0 expected 1"); end
      checks++; if (max_gain != 255)  begin errors++; $display("FAIL basic_gain_peak: got %0d expected 255", max_gain); end
      checks++; if (rel_ticks != 128) begin errors++; $display("FAIL basic_release_ticks: got %0d expected 128", rel_ticks); end
      checks++; if (active !== 1'b0)  begin errors++; $display("FAIL basic_active_at_done: got %0b expected 0", active); end
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_dur0_rest();
      int c0, c1, c2, c3;
      bit s0, s1, s2, s3, f0, f1, f2, f3;
      run_note(0, 0, c0, s0, f0);
      run_note(0, 1, c1, s1, f1);
      run_note(5, 0, c2, s2, f2);
      run_note(5, 1, c3, s3, f3);
      checks++; if (!(f0 && f1 && f2 && f3)) begin errors++; $display("FAIL dur0_finished: got %0b%0b%0b%0b expected 1111", f0, f1, f2, f3); end
      checks++; if (c0 != c1) begin errors++; $display("FAIL dur0_rest_length: got %0d expected %0d", c0, c1); end
      checks++; if (c2 != c3) begin errors++; $display("FAIL dur0_note_length: got %0d expected %0d", c2, c3); end
      checks++; if (s0 || s1) begin errors++; $display("FAIL rest_step_zero: got nonzero step expected 0"); end
      checks++; if (!s2)      begin errors++; $display("FAIL note5_step_seen: got 0 expected nonzero step"); end
   endtask

   task automatic test_retrigger();
      int d0, nb;
      bit fin;
      cyc(1'b1, 30, 1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      repeat (30) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      repeat (10) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      checks++; if (gain !== 8'd100) begin errors++; $display("FAIL retrig_pre_gain: got %0d expected 100", gain); end
      d0 = done_cnt;
      cyc(1'b1, 50, 2, 1'b1, 1'b0, 1'b1);
      checks++; if (gain !== 8'd100) begin errors++; $display("FAIL retrig_lookup_gain: got %0d expected 100", gain); end
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (step_size !== 20'(ref_step(50))) begin
         errors++; $display("FAIL retrig_step: got %0d expected %0d", step_size, ref_step(50));
      end
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      checks++; if (gain !== 8'd104) begin errors++; $display("FAIL retrig_climb: got %0d expected 104", gain); end
      beats_until_release(nb, fin);
      checks++; if (nb != 2)          begin errors++; $display("FAIL retrig_beats: got %0d expected 2", nb); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL retrig_done_pulses: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_pause();
      int g, nb;
      bit fin;
      bit frozen = 1;
      cyc(1'b1, 20, 2, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 40; t++) cyc(1'b0, 0, 0, 1'b1, 1'b0, (t % 4 == 0));
      g = gain;
      for (int t = 1; t <= 500; t++) begin
         cyc(1'b0, 0, 0, 1'b0, (t % 100 == 0), (t % 4 == 0));
         if (int'(gain) != g || active !== 1'b1 || step_size !== 20'(ref_step(20))) frozen = 0;
      end
      checks++; if (!frozen) begin errors++; $display("FAIL pause_frozen: got changed outputs expected gain %0d held", g); end
      beats_until_release(nb, fin);
      checks++; if (nb != 2) begin errors++; $display("FAIL pause_resume_beats: got %0d expected 2", nb); end
      checks++; if (!fin)    begin errors++; $display("FAIL pause_resume_done: got 0 expected 1"); end
   endtask

   task automatic test_load_beat();
      int nb;
      bit fin;
      cyc(1'b1, 33, 2, 1'b1, 1'b1, 1'b1);
      checks++; if (gain !== 8'd0) begin errors++; $display("FAIL loadbeat_tick_dropped: got %0d expected 0", gain); end
      beats_until_release(nb, fin);
      checks++; if (nb != 2) begin errors++; $display("FAIL loadbeat_beats: got %0d expected 2", nb); end
      checks++; if (!fin)    begin errors++; $display("FAIL loadbeat_done: got 0 expected 1"); end
   endtask

   task automatic test_reset_midrelease();
      int d0;
      cyc(1'b1, 10, 1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      repeat (5) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL rst_mid_step: got %0d expected 0", step_size); end
      checks++; if (gain !== 8'd0)       begin errors++; $display("FAIL rst_mid_gain: got %0d expected 0", gain); end
      checks++; if (active !== 1'b0)     begin errors++; $display("FAIL rst_mid_active: got %0b expected 0", active); end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (5) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         bit ld, pl, bt, st;
         ld = ($urandom_range(0, 99) < 2);
         pl = ($urandom_range(0, 9) != 0);
         bt = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 2) == 0);
         cyc(ld, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), pl, bt, st);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dur0_rest();
      test_retrigger();
      test_pause();
      test_load_beat();
      test_reset_midrelease();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
